// File: rtl/limber_gnrl_fifo_ctrl.sv
// limber_gnrl_fifo_ctrl: first-word-fall-through FIFO controller for an external dual-port RAM.
// Define LIMBER_GNRL_FIFO_CNT_EN to add the registered occupancy output cnt.
module limber_gnrl_fifo_ctrl #(
  parameter int DP = 4,
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_vld,
  output logic          i_rdy,
  input  logic [DW-1:0] i_dat,
  output logic          o_vld,
  input  logic          o_rdy,
  output logic [DW-1:0] o_dat,
  output logic [DW-1:0] ram_din,
  output logic [AW-1:0] ram_waddr,
  output logic [AW-1:0] ram_raddr,
  output logic          ram_cs,
  output logic          ram_we,
  input  logic [DW-1:0] ram_dout,
  output logic          full,
  output logic          empty
`ifdef LIMBER_GNRL_FIFO_CNT_EN
  ,
  output logic [AW:0]   cnt
`endif
);
  if (DP != (1 << AW)) begin : g_bad_dp
    $error("DP must equal 2**AW");
  end
  logic [AW:0] r_wptr, r_rptr;
  logic        w_push, w_pop;
  // extra MSB on each pointer tells full from empty when the low bits match
  assign empty     = r_wptr == r_rptr;
  assign full      = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
  assign i_rdy     = ~full;
  assign o_vld     = ~empty;
  assign w_push    = i_vld & ~full;
  assign w_pop     = o_rdy & ~empty;
  assign ram_we    = w_push;
  assign ram_cs    = w_push | ~empty;
  assign ram_din   = i_dat;
  assign ram_waddr = r_wptr[AW-1:0];
  assign ram_raddr = r_rptr[AW-1:0];
  assign o_dat     = ram_dout;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
`ifdef LIMBER_GNRL_FIFO_CNT_EN
  logic [AW:0] r_cnt;
  assign cnt = r_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else        r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
`endif
endmodule

// File: tb/tb_limber_gnrl_fifo_ctrl.sv
// tb_limber_gnrl_fifo_ctrl: queue-based scoreboard with an external RAM model and random traffic.
module tb_limber_gnrl_fifo_ctrl;
  localparam int DP = 4, DW = 8, AW = 2;
  logic          clk, rst_n, i_vld, i_rdy, o_vld, o_rdy, ram_cs, ram_we, full, empty;
  logic [DW-1:0] i_dat, o_dat, ram_din, ram_dout;
  logic [AW-1:0] ram_waddr, ram_raddr;
`ifdef LIMBER_GNRL_FIFO_CNT_EN
  logic [AW:0]   cnt;
`endif
  logic [DW-1:0] mem [DP];
  logic [DW-1:0] exp_q [$];
  int            pend, total, bad;

  limber_gnrl_fifo_ctrl #(.DP(DP), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .i_vld(i_vld), .i_rdy(i_rdy), .i_dat(i_dat),
    .o_vld(o_vld), .o_rdy(o_rdy), .o_dat(o_dat), .ram_din(ram_din),
    .ram_waddr(ram_waddr), .ram_raddr(ram_raddr), .ram_cs(ram_cs), .ram_we(ram_we),
    .ram_dout(ram_dout), .full(full), .empty(empty)
`ifdef LIMBER_GNRL_FIFO_CNT_EN
    , .cnt(cnt)
`endif
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk) if (ram_cs && ram_we) mem[ram_waddr] <= ram_din;
  assign ram_dout = mem[ram_raddr];

  function automatic void chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endfunction

  // monitor: flags against model occupancy, head data against the scoreboard
  always @(negedge clk) if (rst_n) begin : mon
    int occ;
    logic acc;
    occ = exp_q.size() - pend;
    acc = i_vld && occ < DP;
    chk("empty", empty, occ == 0);
    chk("full", full, occ == DP);
    chk("i_rdy", i_rdy, occ < DP);
    chk("o_vld", o_vld, occ != 0);
    chk("ram_we", ram_we, acc);
    chk("ram_cs", ram_cs, acc || occ != 0);
`ifdef LIMBER_GNRL_FIFO_CNT_EN
    chk("cnt", cnt, occ);
`endif
    if (occ != 0) begin
      chk("o_dat", o_dat, exp_q[0]);
      if (o_rdy) void'(exp_q.pop_front());
    end
  end

  task automatic drv(input logic v, input logic [DW-1:0] d, input logic r);
    @(posedge clk);
    #1;
    i_vld = v;
    i_dat = d;
    o_rdy = r;
    pend = 0;
    if (v && exp_q.size() < DP) begin
      exp_q.push_back(d);
      pend = 1;
    end
  endtask

  initial begin
    total = 0; bad = 0; pend = 0;
    rst_n = 0; i_vld = 0; i_dat = 0; o_rdy = 0;
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_o_vld", o_vld, 0);
    chk("rst_ram_we", ram_we, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    chk("rel_i_rdy", i_rdy, 1);
    drv(1, 8'h11, 0);
    drv(0, 8'h00, 0);
    drv(0, 8'h00, 1);
    drv(0, 8'h00, 0);
    for (int i = 1; i <= 5; i++) drv(1, DW'(i), 0);
    for (int i = 0; i < 5; i++) drv(0, 8'h00, 1);
    drv(1, 8'h20, 0);
    for (int i = 0; i < 10; i++) drv(1, DW'(8'h21 + i), 1);
    drv(0, 8'h00, 1);
    drv(0, 8'h00, 1);
    drv(0, 8'h00, 1);
    for (int i = 0; i < 3; i++) drv(1, DW'(8'h50 + i), 0);
    drv(0, 8'h00, 0);
    @(posedge clk);
    #3 rst_n = 0; i_vld = 0; o_rdy = 0;
    #1;
    chk("arst_empty", empty, 1);
    chk("arst_o_vld", o_vld, 0);
    chk("arst_full", full, 0);
    exp_q.delete();
    pend = 0;
    #3 rst_n = 1;
    drv(1, 8'hAA, 0);
    drv(0, 8'h00, 1);
    drv(0, 8'h00, 0);
    for (int i = 0; i < 400; i++)
      drv(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)));
    for (int i = 0; i < DP + 2; i++) drv(0, 8'h00, 1);
    @(posedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
